ps2_keyboard_rx: RTL

Receives PS/2 keyboard frames and turns them into key events for the typing-game logic. The block oversamples the PS/2 clock and data lines on the 50 MHz system clock and deserialises 11-bit frames. It tracks the make, break (F0) and extended (E0) prefixes, and emits the scancode of each released key with a one-cycle `ready` pulse. It drives the `scancode`/`ready` inputs of the game state machine, which acts on key release.

---
 rtl/ps2_keyboard_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// ---------------------------------------------------------------------------
// Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop), tracks the E0 (extended) and F0 (break) prefixes and reports each
// released key to the game state machine.
//
// Ports:
//   clk        50 MHz system clock
//   reset      synchronous, active-high reset
//   ps2_clk    raw PS/2 clock from the keyboard (asynchronous, idles high)
//   ps2_data   raw PS/2 data from the keyboard (asynchronous, idles high)
//   scancode   code of the last released key, held until the next release
//   extended   last released key carried an E0 prefix (updates with scancode)
//   ready      one-cycle pulse when a release event completes
//   key_down   high while the last make code has not yet been released
//   make_code  last make code received (never E0/F0)
//   frame_err  one-cycle pulse on parity error, stop-bit error or timeout
//   state_dbg  current frame state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
// Handshake: ready is a push-only valid with no ready/backpressure return;
// scancode/extended are stable from the ready cycle until the next pulse,
// so the consumer must act on the single cycle ready is high.
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       extended,
    output logic       ready,
    output logic       key_down,
    output logic [7:0] make_code,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Last timeout count value; expiry happens on the cycle the counter
    // would otherwise step to TIMEOUT_CYCLES.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Synchronisers and falling-edge history; idle-high lines reset to 1.
    logic clk_s1, clk_s2, clk_hist;
    logic data_s1, data_s2;
    logic fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_hist <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_hist <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall = clk_hist & ~clk_s2;

    // Frame state machine
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [15:0] tmo_q, tmo_d;
    logic        byte_ok;
    logic        err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        byte_ok   = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = 16'd0;
                // A high bit while idle is ignored silently.
                if (fall && !data_s2) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                if (fall) begin
                    shift_d   = {data_s2, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (fall) begin
                    par_d   = data_s2;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall) begin
                    // Odd parity: XOR over data and parity must be 1.
                    if (data_s2 && (^{shift_q, par_q}))
                        byte_ok = 1'b1;
                    else
                        err = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Mid-frame watchdog; an edge in the expiry cycle wins.
        if (state_q != S_IDLE) begin
            if (fall) begin
                tmo_d = 16'd0;
            end else if (tmo_q == TMO_LAST) begin
                state_d = S_IDLE;
                tmo_d   = 16'd0;
                err     = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    assign state_dbg = state_q;

    // Byte decoder: prefixes, make/break tracking, registered outputs.
    logic brk_pend, ext_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            brk_pend  <= 1'b0;
            ext_pend  <= 1'b0;
            scancode  <= 8'h00;
            extended  <= 1'b0;
            ready     <= 1'b0;
            key_down  <= 1'b0;
            make_code <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            ready     <= 1'b0;
            frame_err <= err;
            if (err) begin
                // Drop any half-seen prefix so the next byte starts clean.
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
            end else if (byte_ok) begin
                if (shift_q == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (brk_pend) begin
                    scancode <= shift_q;
                    extended <= ext_pend;
                    ready    <= 1'b1;
                    if (shift_q == make_code) key_down <= 1'b0;
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                end else begin
                    make_code <= shift_q;
                    key_down  <= 1'b1;
                    ext_pend  <= 1'b0;
                end
            end
        end
    end

endmodule
